// File: rtl/ma_data_mem.sv
// Memory-access stage: word-organised little-endian data memory with byte-lane
// stores, sign/zero-extended loads, misalignment detection and a debug read port.
module ma_data_mem #(
  parameter int NBITS  = 32,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic [NBITS-1:0]  i_eff_addr,
  input  logic [1:0]        i_flg_mem_size,
  input  logic              i_flg_unsign,
  input  logic              i_flg_mem_wr_en,
  input  logic              i_flg_mem_rd_en,
  input  logic [NBITS-1:0]  i_store_data,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [NBITS-1:0]  o_load_data,
  output logic              o_misalign,
  output logic              o_err_sticky,
  output logic [CNT_W-1:0]  o_store_cnt,
  output logic [NBITS-1:0]  o_dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = NBITS / 8;

  logic [DEPTH-1:0][LANES-1:0][7:0] mem_q, mem_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             err_q, err_d;

  logic [ADDR_W-1:0]     widx;
  logic [1:0]            off;
  logic                  is_byte, is_half, is_word, mis_cond, commit;
  logic [LANES-1:0]      lane_we;
  logic [LANES-1:0][7:0] lane_wd;
  logic [LANES-1:0][7:0] rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;

  // Address bits above the word index alias onto the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^i_eff_addr[NBITS-1:ADDR_W+2];

  assign widx    = i_eff_addr[ADDR_W+1:2];
  assign off     = i_eff_addr[1:0];
  assign is_byte = (i_flg_mem_size == 2'b00);
  assign is_half = (i_flg_mem_size == 2'b01);
  assign is_word = i_flg_mem_size[1];

  assign mis_cond   = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign o_misalign = (i_flg_mem_rd_en | i_flg_mem_wr_en) & mis_cond;
  assign commit     = i_step & i_flg_mem_wr_en & ~o_misalign;

  // Sub-word store data is replicated so each lane picks its own byte.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_we[l] = is_word
                      | (is_half & (off[1] == 1'(l >> 1)))
                      | (is_byte & (off == 2'(l)));
    assign lane_wd[l] = is_byte ? i_store_data[7:0]
                      : is_half ? i_store_data[8*(l%2) +: 8]
                      :           i_store_data[8*l +: 8];
  end

  always_comb begin
    mem_d = mem_q;
    if (commit) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) mem_d[widx][l] = lane_wd[l];
      end
    end
  end

  assign cnt_d = cnt_q + CNT_W'(commit);
  assign err_d = err_q | (i_step & o_misalign);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rd_word = mem_q[widx];
  assign rd_byte = rd_word[off];
  assign rd_half = off[1] ? rd_word[3:2] : rd_word[1:0];

  // A misaligned address has no well-defined data, so it reads as zero.
  always_comb begin
    o_load_data = '0;
    if (!mis_cond) begin
      if (is_byte)
        o_load_data = {{(NBITS-8){~i_flg_unsign & rd_byte[7]}}, rd_byte};
      else if (is_half)
        o_load_data = {{(NBITS-16){~i_flg_unsign & rd_half[15]}}, rd_half};
      else
        o_load_data = rd_word;
    end
  end

  assign o_dbg_data   = mem_q[i_dbg_addr];
  assign o_store_cnt  = cnt_q;
  assign o_err_sticky = err_q;

endmodule

// File: tb/tb_ma_data_mem.sv
// Bench for ma_data_mem: directed literal checks plus randomized traffic,
// compared every cycle against a word-array reference model.
module tb_ma_data_mem;
  localparam int NBITS = 32, ADDR_W = 6, CNT_W = 4, DEPTH = 64;

  logic clk = 1'b0;
  logic rst, step, wr, rd, uns;
  logic [31:0] addr, sd;
  logic [1:0] size;
  logic [ADDR_W-1:0] dbg;
  logic [31:0] ld, dbgd;
  logic misal, err;
  logic [CNT_W-1:0] cnt;

  int checks = 0, failures = 0;
  logic [31:0] mm [DEPTH];
  int unsigned m_cnt = 0;
  bit m_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  ma_data_mem #(.NBITS(NBITS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_step(step), .i_eff_addr(addr),
    .i_flg_mem_size(size), .i_flg_unsign(uns), .i_flg_mem_wr_en(wr),
    .i_flg_mem_rd_en(rd), .i_store_data(sd), .i_dbg_addr(dbg),
    .o_load_data(ld), .o_misalign(misal), .o_err_sticky(err),
    .o_store_cnt(cnt), .o_dbg_data(dbgd)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit mis(input logic [31:0] a, input logic [1:0] s);
    int unsigned o = a % 4;
    return (s == 2'd1 && (o % 2) == 1) || (s >= 2'd2 && o != 0);
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] w, v;
    int unsigned o;
    if (mis(a, s)) return 32'd0;
    w = mm[(a >> 2) % DEPTH];
    o = a % 4;
    if (s == 2'd0) begin
      v = (w >> (8 * o)) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (s == 2'd1) begin
      v = (w >> (8 * o)) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Reference model: updates at the clock edge from the spec's rules.
  always @(posedge clk) begin
    if (rst) begin
      foreach (mm[i]) mm[i] = 32'd0;
      m_cnt = 0;
      m_err = 0;
    end else if (step) begin
      if ((rd || wr) && mis(addr, size)) begin
        m_err = 1;
      end else if (wr) begin
        int unsigned idx, o;
        logic [31:0] mask;
        idx  = (addr >> 2) % DEPTH;
        o    = addr % 4;
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        mm[idx] = (mm[idx] & ~(mask << (8 * o))) | ((sd & mask) << (8 * o));
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("misalign", {31'd0, misal}, {31'd0, (rd || wr) && mis(addr, size)});
      if (!(mis(addr, size) && !rd)) chk("load", ld, mload(addr, size, uns));
      chk("dbg", dbgd, mm[dbg]);
      chk("cnt", {28'd0, cnt}, m_cnt);
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic drv(input logic st, input logic w, input logic r, input logic [31:0] a,
                     input logic [1:0] s, input logic u, input logic [31:0] d,
                     input logic [ADDR_W-1:0] dg);
    step = st; wr = w; rd = r; addr = a; size = s; uns = u; sd = d; dbg = dg;
  endtask

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic probe(input string nm, input logic [31:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] exp);
    drv(0, 0, 1, a, s, u, 32'd0, 6'd4);
    at_neg();
    chk(nm, ld, exp);
  endtask

  initial begin
    rst = 1;
    drv(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 6'd0);
    repeat (2) go();
    rst = 0;
    chk_en = 1;
    at_neg();
    chk("rst_cnt", {28'd0, cnt}, 32'd0);
    chk("rst_dbg", dbgd, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    drv(1, 1, 0, 32'h10, 2'd2, 0, 32'hDEADBEEF, 6'd4);
    go();
    drv(0, 0, 1, 32'h10, 2'd2, 0, 32'd0, 6'd4);
    at_neg();
    chk("word_dbg", dbgd, 32'hDEADBEEF);
    chk("word_load", ld, 32'hDEADBEEF);
    chk("word_cnt", {28'd0, cnt}, 32'd1);

    drv(1, 1, 0, 32'h11, 2'd0, 0, 32'hAAAAAA7F, 6'd4);
    go();
    probe("byte_merge", 32'h10, 2'd2, 0, 32'hDEAD7FEF);
    probe("sbyte_13",   32'h13, 2'd0, 0, 32'hFFFFFFDE);
    probe("ubyte_13",   32'h13, 2'd0, 1, 32'h000000DE);
    probe("shalf_12",   32'h12, 2'd1, 0, 32'hFFFFDEAD);
    probe("uhalf_10",   32'h10, 2'd1, 1, 32'h00007FEF);

    drv(1, 1, 0, 32'h22, 2'd2, 0, 32'h11223344, 6'd8);
    at_neg();
    chk("mis_flag", {31'd0, misal}, 32'd1);
    go();
    drv(0, 0, 1, 32'h22, 2'd2, 0, 32'd0, 6'd8);
    at_neg();
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_mem", dbgd, 32'd0);
    chk("mis_cnt", {28'd0, cnt}, 32'd2);
    chk("mis_load", ld, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, 1, 32'(4 * i), 2'd2, 0, 32'd0, 6'd0);
      go();
    end
    at_neg();
    chk("err_sticky", {31'd0, err}, 32'd1);

    drv(0, 1, 0, 32'h30, 2'd2, 0, 32'hCAFEF00D, 6'd12);
    repeat (5) go();
    at_neg();
    chk("nostep_mem", dbgd, 32'd0);
    chk("nostep_cnt", {28'd0, cnt}, 32'd2);
    step = 1;
    go();
    drv(0, 0, 0, 32'h30, 2'd2, 0, 32'd0, 6'd12);
    at_neg();
    chk("step_mem", dbgd, 32'hCAFEF00D);
    chk("step_cnt", {28'd0, cnt}, 32'd3);

    drv(1, 1, 0, 32'h104, 2'd2, 0, 32'h12345678, 6'd1);
    go();
    drv(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 6'd1);
    at_neg();
    chk("alias_dbg", dbgd, 32'h12345678);

    for (int i = 0; i < 11; i++) begin
      drv(1, 1, 0, 32'(32'h80 + 4 * i), 2'd2, 0, $urandom, 6'd0);
      go();
    end
    drv(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 6'd0);
    at_neg();
    chk("cnt_full", {28'd0, cnt}, 32'd15);
    drv(1, 1, 0, 32'hC0, 2'd2, 0, 32'h55AA55AA, 6'd48);
    go();
    drv(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 6'd48);
    at_neg();
    chk("cnt_wrap", {28'd0, cnt}, 32'd0);
    chk("wrap_mem", dbgd, 32'h55AA55AA);

    drv(1, 1, 0, 32'h40, 2'd2, 0, 32'hFFFFFFFF, 6'd16);
    rst = 1;
    go();
    rst = 0;
    drv(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 6'd16);
    at_neg();
    chk("rst_store_mem", dbgd, 32'd0);
    chk("rst_store_cnt", {28'd0, cnt}, 32'd0);
    chk("rst_store_err", {31'd0, err}, 32'd0);

    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom,
          6'($urandom_range(0, DEPTH - 1)));
      go();
    end
    rst = 0;
    drv(0, 0, 0, 32'd0, 2'd0, 0, 32'd0, 6'd0);
    at_neg();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
